// File: rtl/cnet_wr_drain.sv
// cnet_wr_drain: read side of the CPCI write FIFO. Pops {address, data}
// word pairs and issues each pair as one CNET register-bus write using a
// req/ack handshake. Every request is bounded by a timeout; abandoned
// writes are counted in a saturating error counter.
//
// Handshake: cnet_req is registered and rises on the edge that pops the
// data word. While cnet_req=1, cnet_addr/cnet_wr_data are held stable and
// cnet_ack is sampled every cycle; a write completes on the first edge
// that sees cnet_ack=1. cnet_ack is ignored whenever cnet_req=0.
//
// state_dbg exposes the FSM state (0=IDLE, 1=DATA, 2=REQ) for checkers.
module cnet_wr_drain #(
    parameter int TIMEOUT      = 16,
    parameter int TIMEOUT_BITS = 5,
    parameter int ERR_CNT_BITS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    output logic [31:0]             cnet_addr,
    output logic [31:0]             cnet_wr_data,
    output logic                    cnet_req,
    input  logic                    cnet_ack,
    output logic                    done,
    output logic                    timeout,
    output logic [ERR_CNT_BITS-1:0] err_cnt,
    output logic [1:0]              state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_REQ  = 2'd2
    } state_t;

    localparam logic [TIMEOUT_BITS-1:0] TCNT_LAST = TIMEOUT_BITS'(TIMEOUT - 1);
    localparam logic [ERR_CNT_BITS-1:0] ERR_MAX   = {ERR_CNT_BITS{1'b1}};

    state_t                    state_q,   state_d;
    logic [31:0]               addr_q,    addr_d;
    logic [31:0]               data_q,    data_d;
    logic                      req_q,     req_d;
    logic                      done_q,    done_d;
    logic                      timeout_q, timeout_d;
    logic [TIMEOUT_BITS-1:0]   tcnt_q,    tcnt_d;
    logic [ERR_CNT_BITS-1:0]   err_cnt_q, err_cnt_d;
    logic                      pop_en;

    // Pop only in the collecting states and never from an empty FIFO;
    // deliberately independent of cnet_ack.
    always_comb begin
        pop_en = (state_q == ST_IDLE || state_q == ST_DATA) && !fifo_empty && !reset;
    end

    // Next-state and datapath: collect address, collect data, then hold the
    // request until ack (which wins a tie with the last timeout cycle).
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        req_d     = req_q;
        tcnt_d    = tcnt_q;
        err_cnt_d = err_cnt_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_d = 1'b0;
                if (pop_en) begin
                    addr_d  = fifo_dout;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                req_d = 1'b0;
                if (pop_en) begin
                    data_d  = fifo_dout;
                    req_d   = 1'b1;
                    tcnt_d  = '0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (cnet_ack) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (tcnt_q == TCNT_LAST) begin
                    req_d     = 1'b0;
                    timeout_d = 1'b1;
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_BITS'(1);
                    end
                    state_d = ST_IDLE;
                end else begin
                    tcnt_d = tcnt_q + TIMEOUT_BITS'(1);
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any partly collected pair.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            tcnt_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            req_q     <= req_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            tcnt_q    <= tcnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Output mapping.
    always_comb begin
        fifo_rd_en   = pop_en;
        cnet_addr    = addr_q;
        cnet_wr_data = data_q;
        cnet_req     = req_q;
        done         = done_q;
        timeout      = timeout_q;
        err_cnt      = err_cnt_q;
        state_dbg    = state_q;
    end

endmodule

// File: tb/tb_cnet_wr_drain.sv
// Bench for cnet_wr_drain: cycle-by-cycle vector table for the basic write
// path, then hand-written sequences for timeout, tie, back-to-back pairs,
// async reset and error-counter saturation.
module tb_cnet_wr_drain;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fifo_dout;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] cnet_addr;
    logic [31:0] cnet_wr_data;
    logic        cnet_req;
    logic        cnet_ack;
    logic        done;
    logic        timeout;
    logic [7:0]  err_cnt;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] fifo_q[$];
    logic [63:0] exp_q[$];

    cnet_wr_drain #(.TIMEOUT(16), .TIMEOUT_BITS(5), .ERR_CNT_BITS(8)) dut (
        .clk(clk), .reset(reset),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .cnet_addr(cnet_addr), .cnet_wr_data(cnet_wr_data),
        .cnet_req(cnet_req), .cnet_ack(cnet_ack),
        .done(done), .timeout(timeout), .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    typedef struct {
        logic        empty;
        logic [31:0] dout;
        logic        ack;
        int          reps;
        logic        e_rd;
        logic        e_req;
        logic        e_done;
        logic        e_to;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic em, input logic [31:0] d, input logic ack,
                                input int reps, input logic rd, input logic rq,
                                input logic dn, input logic to, input logic [31:0] a,
                                input logic [31:0] wd, input logic [1:0] st);
        vec_t v;
        v.empty = em; v.dout = d; v.ack = ack; v.reps = reps;
        v.e_rd = rd; v.e_req = rq; v.e_done = dn; v.e_to = to;
        v.e_addr = a; v.e_data = wd; v.e_st = st;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Applies one table row (possibly repeated); called at posedge+1.
    task automatic apply_vec(input vec_t v, input int idx);
        for (int r = 0; r < v.reps; r++) begin
            fifo_empty = v.empty;
            fifo_dout  = v.dout;
            cnet_ack   = v.ack;
            @(negedge clk);
            check($sformatf("v%0d.%0d rd_en", idx, r),   32'(fifo_rd_en),   32'(v.e_rd));
            check($sformatf("v%0d.%0d req", idx, r),     32'(cnet_req),     32'(v.e_req));
            check($sformatf("v%0d.%0d done", idx, r),    32'(done),         32'(v.e_done));
            check($sformatf("v%0d.%0d timeout", idx, r), 32'(timeout),      32'(v.e_to));
            check($sformatf("v%0d.%0d addr", idx, r),    cnet_addr,         v.e_addr);
            check($sformatf("v%0d.%0d data", idx, r),    cnet_wr_data,      v.e_data);
            check($sformatf("v%0d.%0d state", idx, r),   32'(state_dbg),    32'(v.e_st));
            check($sformatf("v%0d.%0d err_cnt", idx, r), 32'(err_cnt),      32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    // Driver: one cycle against the FIFO model; called at posedge+1.
    task automatic step(input logic ack, output logic s_rd, output logic s_req,
                        output logic s_done, output logic s_to);
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
        cnet_ack   = ack;
        @(negedge clk);
        s_rd   = fifo_rd_en;
        s_req  = cnet_req;
        s_done = done;
        s_to   = timeout;
        if (s_rd && fifo_empty) check("underflow", 32'(s_rd), 32'd0);
        if (s_done || s_to) begin
            if (exp_q.size() == 0) begin
                check("scoreboard.empty", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("sb.addr", cnet_addr, e[63:32]);
                check("sb.data", cnet_wr_data, e[31:0]);
            end
        end
        @(posedge clk);
        if (s_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
        #1;
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [31:0] d);
        fifo_q.push_back(a);
        fifo_q.push_back(d);
        exp_q.push_back({a, d});
    endtask

    // Runs one transaction to completion; ack_at = req cycle carrying ack (0 = never).
    task automatic run_pair(input int ack_at, output int req_cycles,
                            output int dones, output int tos);
        logic rd, rq, dn, to;
        req_cycles = 0; dones = 0; tos = 0;
        for (int k = 0; k < 60; k++) begin
            step(cnet_req && (req_cycles + 1 == ack_at), rd, rq, dn, to);
            if (rq) req_cycles++;
            if (dn) dones++;
            if (to) tos++;
            if (dn || to) break;
        end
        if (dones + tos == 0) check("run_pair.bound", 32'd0, 32'd1);
    endtask

    initial begin
        logic rd, rq, dn, to;
        int   rc, nd, nt, pops, rises, tot_to;
        int   rise_idx[2];
        logic prev_req;

        vecs[0]  = mk(1, 32'h0,        0, 1,  0, 0, 0, 0, 32'h0,        32'h0,        2'd0);
        vecs[1]  = mk(0, 32'h40,       0, 1,  1, 0, 0, 0, 32'h0,        32'h0,        2'd0);
        vecs[2]  = mk(0, 32'hDEADBEEF, 0, 1,  1, 0, 0, 0, 32'h40,       32'h0,        2'd1);
        vecs[3]  = mk(1, 32'h0,        0, 1,  0, 1, 0, 0, 32'h40,       32'hDEADBEEF, 2'd2);
        vecs[4]  = mk(1, 32'h0,        0, 1,  0, 1, 0, 0, 32'h40,       32'hDEADBEEF, 2'd2);
        vecs[5]  = mk(1, 32'h0,        1, 1,  0, 1, 0, 0, 32'h40,       32'hDEADBEEF, 2'd2);
        vecs[6]  = mk(1, 32'h0,        0, 1,  0, 0, 1, 0, 32'h40,       32'hDEADBEEF, 2'd0);
        vecs[7]  = mk(1, 32'h0,        1, 1,  0, 0, 0, 0, 32'h40,       32'hDEADBEEF, 2'd0);
        vecs[8]  = mk(0, 32'h100,      0, 1,  1, 0, 0, 0, 32'h40,       32'hDEADBEEF, 2'd0);
        vecs[9]  = mk(1, 32'h0,        1, 10, 0, 0, 0, 0, 32'h100,      32'hDEADBEEF, 2'd1);
        vecs[10] = mk(0, 32'h12345678, 0, 1,  1, 0, 0, 0, 32'h100,      32'hDEADBEEF, 2'd1);
        vecs[11] = mk(0, 32'hAAAA0000, 0, 1,  0, 1, 0, 0, 32'h100,      32'h12345678, 2'd2);
        vecs[12] = mk(0, 32'hAAAA0000, 1, 1,  0, 1, 0, 0, 32'h100,      32'h12345678, 2'd2);
        vecs[13] = mk(0, 32'hAAAA0000, 0, 1,  1, 0, 1, 0, 32'h100,      32'h12345678, 2'd0);
        vecs[14] = mk(0, 32'h55555555, 0, 1,  1, 0, 0, 0, 32'hAAAA0000, 32'h12345678, 2'd1);
        vecs[15] = mk(1, 32'h0,        1, 1,  0, 1, 0, 0, 32'hAAAA0000, 32'h55555555, 2'd2);
        vecs[16] = mk(1, 32'h0,        0, 1,  0, 0, 1, 0, 32'hAAAA0000, 32'h55555555, 2'd0);
        vecs[17] = mk(1, 32'h0,        0, 1,  0, 0, 0, 0, 32'hAAAA0000, 32'h55555555, 2'd0);

        // Reset state, with a non-empty FIFO to show rd_en is forced low.
        reset = 1'b1; fifo_empty = 1'b0; fifo_dout = 32'h99; cnet_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.rd_en",   32'(fifo_rd_en), 32'd0);
        check("rst.req",     32'(cnet_req),   32'd0);
        check("rst.done",    32'(done),       32'd0);
        check("rst.timeout", 32'(timeout),    32'd0);
        check("rst.addr",    cnet_addr,       32'd0);
        check("rst.data",    cnet_wr_data,    32'd0);
        check("rst.err_cnt", 32'(err_cnt),    32'd0);
        check("rst.state",   32'(state_dbg),  32'd0);
        fifo_empty = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic write, stall in DATA, ack outside REQ, refill during REQ.
        for (int i = 0; i < 18; i++) apply_vec(vecs[i], i);

        // Never acked: req high exactly 16 cycles, then timeout.
        push_pair(32'h200, 32'h11);
        run_pair(0, rc, nd, nt);
        check("to.req_cycles", 32'(rc), 32'd16);
        check("to.timeouts",   32'(nt), 32'd1);
        check("to.dones",      32'(nd), 32'd0);
        check("to.err_cnt",    32'(err_cnt), 32'd1);
        step(1'b0, rd, rq, dn, to);
        check("to.pulse_len",  32'(to), 32'd0);

        // Next pair processed normally.
        push_pair(32'h300, 32'h22);
        run_pair(1, rc, nd, nt);
        check("after_to.req_cycles", 32'(rc), 32'd1);
        check("after_to.dones",      32'(nd), 32'd1);
        check("after_to.err_cnt",    32'(err_cnt), 32'd1);

        // Ack in the 16th req cycle: ack wins.
        push_pair(32'h400, 32'h33);
        run_pair(16, rc, nd, nt);
        check("tie.req_cycles", 32'(rc), 32'd16);
        check("tie.dones",      32'(nd), 32'd1);
        check("tie.timeouts",   32'(nt), 32'd0);
        check("tie.err_cnt",    32'(err_cnt), 32'd1);
        step(1'b0, rd, rq, dn, to);
        check("tie.no_late_to", 32'(to), 32'd0);

        // Two preloaded pairs, ack in the first req cycle.
        push_pair(32'h500, 32'hCAFE0001);
        push_pair(32'h504, 32'hCAFE0002);
        pops = 0; rises = 0; nd = 0; prev_req = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(cnet_req, rd, rq, dn, to);
            if (rd) pops++;
            if (dn) nd++;
            if (rq && !prev_req) begin
                if (rises < 2) rise_idx[rises] = k;
                rises++;
            end
            prev_req = rq;
        end
        check("b2b.pops",       32'(pops), 32'd4);
        check("b2b.dones",      32'(nd), 32'd2);
        check("b2b.rises",      32'(rises), 32'd2);
        check("b2b.period",     32'(rise_idx[1] - rise_idx[0]), 32'd3);
        check("b2b.fifo_empty", 32'(fifo_q.size()), 32'd0);

        // Async reset in the middle of a REQ cycle.
        push_pair(32'h600, 32'h44);
        fifo_q.push_back(32'h700);
        step(1'b0, rd, rq, dn, to);
        step(1'b0, rd, rq, dn, to);
        check("arst.pre_req", 32'(cnet_req), 32'd1);
        fifo_empty = 1'b0;
        fifo_dout  = 32'h700;
        #2 reset = 1'b1;
        #1;
        check("arst.req",     32'(cnet_req),   32'd0);
        check("arst.rd_en",   32'(fifo_rd_en), 32'd0);
        check("arst.err_cnt", 32'(err_cnt),    32'd0);
        check("arst.addr",    cnet_addr,       32'd0);
        check("arst.data",    cnet_wr_data,    32'd0);
        check("arst.state",   32'(state_dbg),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_empty = 1'b1;

        // 300 timeouts saturate the counter at 255.
        tot_to = 0;
        for (int i = 0; i < 300; i++) begin
            push_pair(32'h1000 + 32'(i), 32'hF000_0000 + 32'(i));
            run_pair(0, rc, nd, nt);
            tot_to += nt;
            if (i == 0)   check("sat.err_1",   32'(err_cnt), 32'd1);
            if (i == 253) check("sat.err_254", 32'(err_cnt), 32'd254);
            if (i == 254) check("sat.err_255", 32'(err_cnt), 32'd255);
        end
        check("sat.total_to", 32'(tot_to), 32'd300);
        check("sat.err_cnt",  32'(err_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
